// File: rtl/robs_mult_sequencer_pkg.sv
// Shared types and default parameters for the Robertson multiplier job sequencer.
// Contents:
//   seq_state_t  - sequencer FSM states
//   DEF_WIDTH    - default operand width (product is 2*DEF_WIDTH)
//   DEF_CW       - default latency counter width
//   DEF_TIMEOUT  - default WAIT-cycle limit before a job is aborted
package robs_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } seq_state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_CW      = 8;
  localparam int DEF_TIMEOUT = 40;

endpackage

// File: rtl/robs_mult_sequencer_if.sv
// Operand-in and result-out handshake bundle of the multiplier sequencer.
// Signals:
//   in_valid/in_ready              operand pair handshake
//   in_multiplier/in_multiplicand  signed operands, WIDTH bits
//   out_valid/out_ready            result handshake
//   out_product                    2*WIDTH-bit product (0 on timeout)
//   out_cycles                     CW-bit measured latency
//   out_timeout                    job aborted without done
// Modports:
//   master - operand source / result consumer side
//   slave  - sequencer side
interface robs_mult_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_multiplier;
  logic [WIDTH-1:0]     in_multiplicand;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_product;
  logic [CW-1:0]        out_cycles;
  logic                 out_timeout;

  modport master (
    output in_valid, in_multiplier, in_multiplicand, out_ready,
    input  in_ready, out_valid, out_product, out_cycles, out_timeout
  );

  modport slave (
    input  in_valid, in_multiplier, in_multiplicand, out_ready,
    output in_ready, out_valid, out_product, out_cycles, out_timeout
  );
endinterface

// File: rtl/robs_mult_sequencer_sat_counter.sv
// Saturating up-counter used to measure WAIT latency.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears count
//   clr    synchronous clear (priority over en)
//   en     count enable; holds at all-ones once reached
//   count  CW-bit counter value
module robs_sat_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/robs_mult_sequencer.sv
// Job sequencer between an operand source, a Robertson multiplier and a
// result consumer. Accepts one operand pair, holds it on the multiplier
// inputs, restarts the multiplier for one cycle, waits for done (bounded by
// TIMEOUT) and offers product, latency and timeout flag to the consumer.
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   bus (slave)         operand-in / result-out handshakes
//   mult_start          multiplier reset/restart (also high while in reset)
//   mult_multiplier     latched multiplier operand
//   mult_multiplicand   latched multiplicand operand
//   mult_product        product from the multiplier
//   mult_done           multiplier done
//   busy                sequencer not idle
//
// state  | meaning
// IDLE   | ready for an operand pair
// LAUNCH | one-cycle multiplier restart, clear latency counter
// WAIT   | count cycles until done or timeout
// RESULT | present result until consumer accepts
module robs_mult_sequencer
  import robs_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CW      = DEF_CW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  robs_mult_sequencer_if.slave bus,
  output logic                 mult_start,
  output logic [WIDTH-1:0]     mult_multiplier,
  output logic [WIDTH-1:0]     mult_multiplicand,
  input  logic [2*WIDTH-1:0]   mult_product,
  input  logic                 mult_done,
  output logic                 busy
);

  seq_state_t           state, state_nx;
  logic [CW-1:0]        cnt;
  logic [CW:0]          cnt_inc;
  logic                 accept;
  logic                 done_hit;
  logic                 tmo_hit;

  logic [WIDTH-1:0]     op_mr;
  logic [WIDTH-1:0]     op_md;
  logic [2*WIDTH-1:0]   res_product;
  logic [CW-1:0]        res_cycles;
  logic                 res_timeout;

  robs_sat_counter #(.CW(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state == LAUNCH),
    .en    (state == WAIT),
    .count (cnt)
  );

  assign cnt_inc = {1'b0, cnt} + 1'b1;
  assign accept  = (state == IDLE) && bus.in_valid;
  // done in the first WAIT cycle may still be the previous job's; ignore it
  assign done_hit = (state == WAIT) && (cnt != '0) && mult_done;
  assign tmo_hit  = (state == WAIT) && (cnt_inc == (CW+1)'(TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = LAUNCH;
      LAUNCH:  state_nx = WAIT;
      WAIT:    if (done_hit || tmo_hit) state_nx = RESULT;
      RESULT:  if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_mr <= '0;
      op_md <= '0;
    end else if (accept) begin
      op_mr <= bus.in_multiplier;
      op_md <= bus.in_multiplicand;
    end
  end

  // done has priority over the timeout when both land in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_product <= '0;
      res_cycles  <= '0;
      res_timeout <= 1'b0;
    end else if (state == LAUNCH) begin
      res_timeout <= 1'b0;
    end else if (done_hit) begin
      res_product <= mult_product;
      res_cycles  <= cnt_inc[CW-1:0];
      res_timeout <= 1'b0;
    end else if (tmo_hit) begin
      res_product <= '0;
      res_cycles  <= CW'(TIMEOUT);
      res_timeout <= 1'b1;
    end
  end

  // reset feeds mult_start directly so the multiplier is held in reset too
  assign mult_start        = reset | (state == LAUNCH);
  assign mult_multiplier   = op_mr;
  assign mult_multiplicand = op_md;
  assign busy              = (state != IDLE);

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == RESULT);
  assign bus.out_product = res_product;
  assign bus.out_cycles  = res_cycles;
  assign bus.out_timeout = res_timeout;

endmodule

// File: tb/tb_robs_mult_sequencer.sv
// Self-checking bench for robs_mult_sequencer with a behavioural multiplier
// stub whose done latency, stale-done and never-done behaviour are selectable.
module tb_robs_mult_sequencer;

  localparam int W  = 8;
  localparam int CW = 8;
  localparam int TO = 40;

  logic            clk = 1'b0;
  logic            reset;
  logic            mult_start;
  logic [W-1:0]    mult_multiplier, mult_multiplicand;
  logic [2*W-1:0]  mult_product;
  logic            mult_done;
  logic            busy;

  robs_mult_sequencer_if #(.WIDTH(W), .CW(CW)) bus ();

  robs_mult_sequencer #(.WIDTH(W), .CW(CW), .TIMEOUT(TO)) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .mult_start        (mult_start),
    .mult_multiplier   (mult_multiplier),
    .mult_multiplicand (mult_multiplicand),
    .mult_product      (mult_product),
    .mult_done         (mult_done),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] smul(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    logic signed [2*W-1:0] r;
    r = a * b;
    return r;
  endfunction

  // ---------------- multiplier stub ----------------
  int stub_lat   = 3;
  bit stub_never = 1'b0;
  bit stub_stale = 1'b0;
  int wcyc       = 1000;   // index of current WAIT cycle as seen by the stub

  always @(posedge clk) begin
    if (mult_start) wcyc <= 1;
    else if (wcyc < 100000) wcyc <= wcyc + 1;
  end

  logic done_real, done_stale;
  assign done_real  = !mult_start && !stub_never && (wcyc >= stub_lat);
  assign done_stale = stub_stale && (mult_start || wcyc == 1);
  assign mult_done    = done_real | done_stale;
  assign mult_product = done_real ? smul(mult_multiplier, mult_multiplicand) : 16'hBAD0;

  // ---------------- reference model ----------------
  bit              model_idle = 1'b1;
  bit              out_allowed = 1'b0;
  logic [W-1:0]    exp_mr = '0, exp_md = '0;
  logic [2*W-1:0]  exp_product = '0;
  logic [CW-1:0]   exp_cycles = '0;
  logic            exp_timeout = 1'b0;

  // operands are taken exactly when the model is idle and a pair is offered
  always @(posedge clk) begin
    if (!reset && model_idle && bus.in_valid) begin
      exp_mr     = bus.in_multiplier;
      exp_md     = bus.in_multiplicand;
      model_idle = 1'b0;
    end
  end

  task automatic model_job(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int lat, input bit nv);
    int eff;
    eff = (lat < 2) ? 2 : lat;
    if (!nv && eff <= TO) begin
      exp_product = smul(a, b);
      exp_cycles  = CW'(eff);
      exp_timeout = 1'b0;
    end else begin
      exp_product = '0;
      exp_cycles  = CW'(TO);
      exp_timeout = 1'b1;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!reset) begin
      check("in_ready", bus.in_ready, model_idle);
      check("busy", busy, !model_idle);
      check("mult_multiplier", mult_multiplier, exp_mr);
      check("mult_multiplicand", mult_multiplicand, exp_md);
      if (bus.out_valid) begin
        check("out_valid_allowed", out_allowed, 1);
        check("out_product", bus.out_product, exp_product);
        check("out_cycles", bus.out_cycles, exp_cycles);
        check("out_timeout", bus.out_timeout, exp_timeout);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int lat, input bit nv, input bit st,
                         input int hold, input bit sec,
                         input logic [W-1:0] sa, input logic [W-1:0] sb,
                         input int lp, input int lc, input int lt);
    int n;
    if (!bus.in_valid) @(negedge clk);
    stub_lat   = lat;
    stub_never = nv;
    stub_stale = st;
    model_job(a, b, lat, nv);
    bus.in_valid        = 1'b1;
    bus.in_multiplier   = a;
    bus.in_multiplicand = b;
    n = 0;
    while (model_idle && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("accepted", !model_idle, 1);
    bus.in_valid = 1'b0;
    out_allowed  = 1'b1;
    @(negedge clk);
    check("launch_start", mult_start, 1);
    @(negedge clk);
    check("wait_start_low", mult_start, 0);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("result_valid", bus.out_valid, 1);
    if (lp >= 0) check("lit_product", bus.out_product, 32'(lp));
    if (lc >= 0) check("lit_cycles", bus.out_cycles, 32'(lc));
    if (lt >= 0) check("lit_timeout", bus.out_timeout, 32'(lt));
    if (sec) begin
      bus.in_valid        = 1'b1;
      bus.in_multiplier   = sa;
      bus.in_multiplicand = sb;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    out_allowed   = 1'b0;
    model_idle    = 1'b1;
    check("post_hs_valid", bus.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset               = 1'b1;
    bus.in_valid        = 1'b0;
    bus.in_multiplier   = '0;
    bus.in_multiplicand = '0;
    bus.out_ready       = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_mult_start", mult_start, 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel_in_ready", bus.in_ready, 1);
    check("rel_mult_start", mult_start, 0);
    check("rel_product", bus.out_product, 0);
    check("rel_cycles", bus.out_cycles, 0);
    check("rel_timeout", bus.out_timeout, 0);
    check("rel_op", {mult_multiplier, mult_multiplicand}, 0);

    //      a      b      lat nv st hold sec sa  sb   lit prod  cyc  to
    run_job(8'd5,  8'd3,   3, 0, 0, 0, 0, 8'd0, 8'd0, 16'h000F, 3,  0);
    run_job(8'hFD, 8'd7,   8, 0, 0, 0, 0, 8'd0, 8'd0, 16'hFFEB, 8,  0);
    run_job(8'h80, 8'h80, 16, 0, 0, 0, 0, 8'd0, 8'd0, 16'h4000, 16, 0);
    run_job(8'd2,  8'd9,  10, 0, 0, 0, 0, 8'd0, 8'd0, 16'h0012, 10, 0);
    run_job(8'd6,  8'd6,   5, 0, 1, 0, 0, 8'd0, 8'd0, 16'h0024, 5,  0);
    run_job(8'd4,  8'd4,   5, 1, 0, 0, 0, 8'd0, 8'd0, 16'h0000, 40, 1);
    run_job(8'd3,  8'hFF, 40, 0, 0, 0, 0, 8'd0, 8'd0, 16'hFFFD, 40, 0);
    // backpressure for 20 cycles with a second pair already offered
    run_job(8'd7,  8'hFE,  4, 0, 0, 20, 1, 8'd11, 8'd12, 16'hFFF2, 4, 0);
    run_job(8'd11, 8'd12,  6, 0, 0, 0, 0, 8'd0, 8'd0, 16'h0084, 6,  0);

    // reset in the middle of WAIT
    @(negedge clk);
    stub_never = 1'b1;
    stub_stale = 1'b0;
    bus.in_valid        = 1'b1;
    bus.in_multiplier   = 8'd9;
    bus.in_multiplicand = 8'd9;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("mid_accepted", !model_idle, 1);
    repeat (5) @(negedge clk);
    check("mid_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_mult_start", mult_start, 1);
    exp_mr      = '0;
    exp_md      = '0;
    model_idle  = 1'b1;
    out_allowed = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rel_in_ready", bus.in_ready, 1);
    check("mid_rel_mult_start", mult_start, 0);
    repeat (50) @(negedge clk);
    check("mid_no_result", bus.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/robs_mult_sequencer.md
Name: robs_mult_sequencer

Overview:
Upstream/downstream job sequencer for the Robertson multiplier. It accepts signed operand pairs over a valid/ready handshake and holds them stable on the multiplier inputs. It restarts the multiplier with a one-cycle start pulse, waits for done with a timeout, then presents product, measured latency and a timeout flag over a valid/ready result handshake. It sits between the operand source and the multiplier, and between the multiplier and the result consumer.

Parameters:
WIDTH, 8, operand width; product width is 2*WIDTH
CW, 8, width of the latency counter and out_cycles
TIMEOUT, 40, maximum WAIT cycles before abort; must satisfy 1 < TIMEOUT < 2**CW

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
in_valid  in  1  operand pair valid
in_ready  out  1  sequencer can accept an operand pair
in_multiplier  in  WIDTH  signed multiplier operand
in_multiplicand  in  WIDTH  signed multiplicand operand
mult_start  out  1  drives the multiplier's reset input
mult_multiplier  out  WIDTH  latched multiplier operand to the multiplier
mult_multiplicand  out  WIDTH  latched multiplicand operand to the multiplier
mult_product  in  2*WIDTH  product from the multiplier
mult_done  in  1  multiplier done
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_product  out  2*WIDTH  captured product; 0 on timeout
out_cycles  out  CW  WAIT cycles until done was seen; TIMEOUT on timeout
out_timeout  out  1  1 = job aborted, no done seen
busy  out  1  state != IDLE

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset: state=IDLE; operand, product, cycle and timeout registers cleared to 0.
- Reset output values: in_ready=1 after reset releases, out_valid=0, busy=0.
- mult_start = reset OR (state==LAUNCH). This holds the multiplier in reset whenever the sequencer is in reset.
- States: IDLE, LAUNCH, WAIT, RESULT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch both operands into op registers, go to LAUNCH.
  - mult_done is ignored in IDLE.
- LAUNCH:
  - Lasts exactly 1 cycle; mult_start=1.
  - Clears cnt to 0, clears the timeout register.
  - Always goes to WAIT.
- WAIT:
  - Each cycle, cnt increments, saturating at 2**CW-1.
  - mult_done is masked while cnt==0 (first WAIT cycle), to reject stale done from the previous job.
  - If cnt!=0 and mult_done=1: capture mult_product into out_product; out_cycles=cnt+1; out_timeout=0; go to RESULT.
  - Else if cnt+1==TIMEOUT: out_product=0; out_cycles=TIMEOUT; out_timeout=1; go to RESULT.
  - If done and the timeout condition occur in the same cycle, done wins.
- RESULT:
  - out_valid=1; out_product, out_cycles and out_timeout held stable until the handshake.
  - On out_valid&out_ready: go to IDLE.
  - in_ready=0 (no overlap; throughput is one job per LAUNCH+WAIT+RESULT+IDLE).
- Operand stability:
  - mult_multiplier and mult_multiplicand are driven from the op registers at all times.
  - They change only on an accepted input handshake.
- Output timing: out_* registered except out_valid, in_ready and busy, which decode state. No combinational path from in_valid or out_ready to any output.
- Reset mid-operation: any state returns to IDLE asynchronously; a pending result is discarded and no out_valid is emitted.
- mult_product is sign-extended product bits as delivered; the sequencer performs no arithmetic on it.

Decomposition:
- Package robs_pkg:
  - typedef enum logic [1:0] seq_state_t {IDLE, LAUNCH, WAIT, RESULT}.
  - Default WIDTH/CW/TIMEOUT localparams.
- Sub-module robs_sat_counter:
  - CW-bit counter with sync clear and enable.
  - Saturates at all-ones.
  - Async active-high reset.
- Rest of the logic is inline FSM plus registers.

Test Plan:
- Reset: assert reset mid-WAIT → busy=0, out_valid=0, mult_start=1 while reset high; after release in_ready=1.
- Real multiplier, WIDTH=8: operands 5×3 → out_product=16'h000F, out_timeout=0; -3×7 → 16'hFFEB; -128×-128 → 16'h4000.
- Stub multiplier, done asserted on the L-th WAIT cycle:
  - L=10 → out_cycles=10.
  - Done held high from the prior job during LAUNCH and the first WAIT cycle is ignored; with stub L=5 → out_cycles=5.
- Stub never asserts done → out_valid rises with out_timeout=1, out_cycles=40, out_product=0.
- Stub asserts done on WAIT cycle 40 → done wins: out_timeout=0, out_cycles=40.
- Backpressure:
  - Hold out_ready=0 for 20 cycles → out_* stable, in_ready=0, second in_valid not accepted.
  - Release → handshake, return to IDLE, next pair accepted, mult_multiplier/mult_multiplicand update only then.
